// File: rtl/mem_init_arbiter.sv
// Owns the RAM port: fills it from an image source after reset or re-init,
// then hands it to the CPU and times read data with a valid strobe.
module mem_init_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int INIT_DEPTH = 1024,
    parameter int READ_LAT   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Reinit,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_oe,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [DATA_W-1:0] img_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic              init_done
);

    if (INIT_DEPTH < 1 || INIT_DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("INIT_DEPTH out of range 1..2**ADDR_W");
    end
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $error("READ_LAT out of range 1..4");
    end

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One extra bit so a full-range depth never wraps before the terminal compare
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(INIT_DEPTH - 1);

    state_t              state;
    logic [ADDR_W:0]     cnt;
    logic [READ_LAT-1:0] pipe;
    logic                rd;

    always_comb begin
        ram_addr  = cnt[ADDR_W-1:0];
        ram_wdata = img_data;
        ram_we    = 1'b0;
        ram_rden  = 1'b0;
        rd        = 1'b0;
        if (!Reset) begin
            if (state == INIT) begin
                ram_we = 1'b1;
            end else begin
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                ram_we    = cpu_we;
                rd        = cpu_oe & ~cpu_we;
                ram_rden  = rd;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= INIT;
            cnt       <= '0;
            pipe      <= '0;
            init_done <= 1'b0;
        end else begin
            pipe <= (pipe << 1) | READ_LAT'(rd);
            case (state)
                INIT: begin
                    if (cnt == LAST) begin
                        state     <= RUN;
                        cnt       <= '0;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (Reinit) begin
                        state     <= INIT;
                        cnt       <= '0;
                        init_done <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign cpu_ready  = init_done;
    assign img_addr   = cnt[ADDR_W-1:0];
    assign cpu_rdata  = ram_q;
    assign cpu_rvalid = pipe[READ_LAT-1];

endmodule

// File: tb/tb_mem_init_arbiter.sv
// Random and directed checks of mem_init_arbiter against a cycle-level
// behavioural model with a shadow memory and a read-arrival queue.
module tb_mem_init_arbiter;

    localparam int AW  = 3;
    localparam int DW  = 16;
    localparam int DEP = 8;
    localparam int LAT = 2;

    logic          Clk;
    logic          Reset;
    logic          Reinit;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_we;
    logic          cpu_oe;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic [AW-1:0] img_addr;
    logic [DW-1:0] img_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic          ram_rden;
    logic [DW-1:0] ram_q;
    logic          init_done;

    mem_init_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .INIT_DEPTH(DEP), .READ_LAT(LAT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Reinit(Reinit),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .cpu_oe(cpu_oe),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid), .img_addr(img_addr),
        .img_data(img_data), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rden(ram_rden), .ram_q(ram_q),
        .init_done(init_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Image source and a RAM with LAT cycles of read latency
    assign img_data = DW'(img_addr * 3);

    logic [DW-1:0] mem [DEP];
    logic [DW-1:0] d0, d1;
    always @(posedge Clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        d0 <= mem[ram_addr];
        d1 <= d0;
    end
    assign ram_q = d1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          due;
        logic [15:0] d;
    } rd_t;

    int          cyc = 0;
    bit          mvalid = 0;
    bit          in_run = 0;
    int          idx = 0;
    logic [15:0] smem [DEP];
    rd_t         pend [$];

    task automatic step(bit rst, bit ri, int a, logic [15:0] wd,
                        bit we, bit oe);
        bit          e_we, e_rd, e_rv;
        int          e_addr;
        logic [15:0] e_wd;
        @(posedge Clk);
        #1;
        Reset     = rst;
        Reinit    = ri;
        cpu_addr  = AW'(a);
        cpu_wdata = wd;
        cpu_we    = we;
        cpu_oe    = oe;
        #4;
        e_we   = 0;
        e_rd   = 0;
        e_addr = idx;
        e_wd   = 16'(idx * 3);
        if (!rst) begin
            if (!in_run) begin
                e_we = 1;
            end else begin
                e_addr = a;
                e_wd   = wd;
                e_we   = we;
                e_rd   = oe && !we;
            end
        end
        e_rv = pend.size() > 0 && pend[0].due == cyc;
        if (mvalid) begin
            chk("cpu_ready", cpu_ready, in_run);
            chk("init_done", init_done, in_run);
            chk("ram_we", ram_we, e_we);
            chk("ram_rden", ram_rden, e_rd);
            chk("cpu_rvalid", cpu_rvalid, e_rv);
            chk("img_addr", img_addr, in_run ? 0 : idx);
            if (e_rv) chk("cpu_rdata", cpu_rdata, pend[0].d);
            if (e_we || e_rd) chk("ram_addr", ram_addr, e_addr);
            if (e_we) chk("ram_wdata", ram_wdata, e_wd);
        end
        while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
        if (rst) begin
            in_run = 0;
            idx    = 0;
            pend.delete();
            mvalid = 1;
        end else if (!in_run) begin
            smem[idx] = 16'(idx * 3);
            if (idx == DEP - 1) begin
                in_run = 1;
                idx    = 0;
            end else begin
                idx++;
            end
        end else begin
            if (e_rd) pend.push_back('{cyc + LAT, smem[a]});
            if (we) smem[a] = wd;
            if (ri) begin
                in_run = 0;
                idx    = 0;
            end
        end
        cyc++;
    endtask

    task automatic idle();
        step(0, 0, 0, 16'h0, 0, 0);
    endtask

    initial begin
        Reset     = 1'b1;
        Reinit    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_we    = 1'b0;
        cpu_oe    = 1'b0;

        // Init sequence with the CPU hammering reads throughout
        step(1, 0, 0, 16'h0, 0, 0);
        for (int k = 0; k < DEP; k++) begin
            step(0, 0, 5, 16'h0, 0, 1);
            chk("init_addr", ram_addr, k);
            chk("init_data", ram_wdata, k * 3);
            chk("init_we", ram_we, 1);
            chk("init_rden", ram_rden, 0);
            chk("init_rvalid", cpu_rvalid, 0);
            chk("init_ready", cpu_ready, 0);
        end
        idle();
        chk("done_cyc9", init_done, 1);

        // Read of address 5 arrives exactly LAT cycles later
        step(0, 0, 5, 16'h0, 0, 1);
        idle();
        chk("rv_early", cpu_rvalid, 0);
        idle();
        chk("rv_on_time", cpu_rvalid, 1);
        chk("rd_addr5", cpu_rdata, 16'd15);
        idle();
        chk("rv_late", cpu_rvalid, 0);

        // Write wins over a simultaneous read
        step(0, 0, 3, 16'hBEEF, 1, 1);
        chk("ww_we", ram_we, 1);
        chk("ww_rden", ram_rden, 0);
        idle();
        idle();
        chk("ww_norv", cpu_rvalid, 0);
        step(0, 0, 3, 16'h0, 0, 1);
        idle();
        idle();
        chk("rd_beef", cpu_rdata, 16'hBEEF);

        // Reset in the middle of init restarts from address 0
        step(1, 0, 0, 16'h0, 0, 0);
        for (int k = 0; k < 4; k++) idle();
        step(1, 0, 0, 16'h0, 0, 0);
        for (int k = 0; k < DEP; k++) begin
            idle();
            chk("restart_addr", ram_addr, k);
        end
        idle();
        chk("restart_done", init_done, 1);

        // Re-init with a read in flight
        step(0, 0, 2, 16'h0, 0, 1);
        step(0, 1, 0, 16'h0, 0, 0);
        idle();
        chk("reinit_rv", cpu_rvalid, 1);
        chk("reinit_rd", cpu_rdata, 16'd6);
        chk("reinit_ready", cpu_ready, 0);
        for (int k = 1; k < DEP; k++) idle();
        chk("reinit_busy", init_done, 0);
        idle();
        chk("reinit_done", init_done, 1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(63) == 0, $urandom_range(31) == 0,
                 int'($urandom_range(DEP - 1)), 16'($urandom),
                 $urandom_range(3) == 0, $urandom_range(1) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
